coupled_cell_sync: RTL and testbench

COUPLED_CELL_SYNC -- requirements
Module: coupled_cell_sync

---
 rtl/coupled_cell_sync_pkg.sv | 16 +
 rtl/coupled_cell_sync_if.sv | 10 +
 rtl/coupled_cell_sync_delay_channel.sv | 47 ++++
 rtl/coupled_cell_sync.sv | 96 +++++++++
 tb/tb_coupled_cell_sync.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/coupled_cell_sync_pkg.sv
// Shared constants and sizing helpers for the coupled oscillator cell family.
package ising_pkg;

  localparam int W_RESET = 0;

  // Largest weight magnitude a signed field can hold symmetrically.
  function automatic int wmax_f(input int weight_width);
    return (1 << (weight_width - 1)) - 1;
  endfunction

  // Counter width large enough to hold any count up to max_target without wrapping.
  function automatic int cnt_width_f(input int max_target);
    return ($clog2(max_target + 1) < 1) ? 1 : $clog2(max_target + 1);
  endfunction

endpackage

// File: rtl/coupled_cell_sync_if.sv
// Weight write / commit bus shared between the host side and a coupled cell.
interface coupled_cell_sync_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic        commit;

  modport master (output wready, output wr_addr, output wdata, output commit);
  modport slave  (input wready, input wr_addr, input wdata, input commit);
endinterface

// File: rtl/coupled_cell_sync_delay_channel.sv
// One direction of the cell: follows its phase input after target consecutive mismatching edges.
module delay_channel #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic          rstn,
  input  logic          in,
  input  logic [CW-1:0] target,
  output logic          out
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic [CW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign out     = out_q;

  // A target at or below the running count fires on the next mismatching edge.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (!rstn) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (in == out_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= {1'b0, target}) begin
      out_d = in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_inc[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/coupled_cell_sync.sv
// Coupled phase cell: two delay channels whose delays are steered by a committed signed weight.
module coupled_cell_sync
  import ising_pkg::*;
#(
  parameter int          WEIGHT_WIDTH = 4,
  parameter int          BASE_DELAY   = 8,
  parameter logic [31:0] ADDR         = 32'h0000_0008
) (
  input  logic                           clk,
  input  logic                           axi_rstn,
  input  logic                           rstn,
  input  logic                           sin,
  input  logic                           din,
  output logic                           sout,
  output logic                           dout,
  coupled_cell_sync_if.slave             wbus,
  output logic signed [WEIGHT_WIDTH-1:0] weight_active
);

  localparam int WMAX = wmax_f(WEIGHT_WIDTH);
  localparam int CW   = cnt_width_f(BASE_DELAY + WMAX);
  localparam logic [WEIGHT_WIDTH-1:0] W_MOST_NEG = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
  localparam logic [WEIGHT_WIDTH-1:0] W_NEG_MAX  = WEIGHT_WIDTH'(-WMAX);

  generate
    if (BASE_DELAY < WMAX + 1) begin : g_cfg_check
      $error("coupled_cell_sync: BASE_DELAY must be at least WMAX+1");
    end
  endgenerate

  logic signed [WEIGHT_WIDTH-1:0] shadow_q, shadow_d;
  logic signed [WEIGHT_WIDTH-1:0] active_q, active_d;
  logic signed [WEIGHT_WIDTH-1:0] wr_clamped;
  logic        [WEIGHT_WIDTH-1:0] wr_raw;
  logic                           write_hit;
  logic                           unused_wdata_hi;
  logic        [CW-1:0]           target_s, target_d;
  int                             w_int;

  assign wr_raw          = wbus.wdata[WEIGHT_WIDTH-1:0];
  assign unused_wdata_hi = ^wbus.wdata[31:WEIGHT_WIDTH];
  assign write_hit       = wbus.wready && (wbus.wr_addr == ADDR);
  assign weight_active   = active_q;

  // The lone asymmetric code is folded onto -WMAX; a same-cycle commit picks up the fresh write.
  always_comb begin
    wr_clamped = $signed(wr_raw);
    if (wr_raw == W_MOST_NEG) begin
      wr_clamped = $signed(W_NEG_MAX);
    end
    shadow_d = shadow_q;
    if (write_hit) begin
      shadow_d = wr_clamped;
    end
    active_d = active_q;
    if (wbus.commit) begin
      active_d = shadow_d;
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      shadow_q <= WEIGHT_WIDTH'(W_RESET);
      active_q <= WEIGHT_WIDTH'(W_RESET);
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Mismatch against the opposite channel lengthens the delay; agreement shortens it.
  always_comb begin
    w_int    = int'(active_q);
    target_s = (sin ^ dout) ? CW'(BASE_DELAY + w_int) : CW'(BASE_DELAY - w_int);
    target_d = (din ^ sout) ? CW'(BASE_DELAY + w_int) : CW'(BASE_DELAY - w_int);
  end

  delay_channel #(.CW(CW)) u_ch_s (
    .clk      (clk),
    .axi_rstn (axi_rstn),
    .rstn     (rstn),
    .in       (sin),
    .target   (target_s),
    .out      (sout)
  );

  delay_channel #(.CW(CW)) u_ch_d (
    .clk      (clk),
    .axi_rstn (axi_rstn),
    .rstn     (rstn),
    .in       (din),
    .target   (target_d),
    .out      (dout)
  );

endmodule

// File: tb/tb_coupled_cell_sync.sv
// Directed bench for coupled_cell_sync: latency per weight, cancellation, weight bus and both resets.
module tb_coupled_cell_sync;

  localparam logic [31:0] ADDR = 32'h0000_0008;

  logic clk = 1'b0;
  logic axi_rstn;
  logic rstn;
  logic sin;
  logic din;
  logic sout;
  logic dout;
  logic signed [3:0] weight_active;
  int checks = 0;
  int errors = 0;
  int n;

  coupled_cell_sync_if wif();

  coupled_cell_sync #(
    .WEIGHT_WIDTH (4),
    .BASE_DELAY   (8),
    .ADDR         (ADDR)
  ) dut (
    .clk           (clk),
    .axi_rstn      (axi_rstn),
    .rstn          (rstn),
    .sin           (sin),
    .din           (din),
    .sout          (sout),
    .dout          (dout),
    .wbus          (wif.slave),
    .weight_active (weight_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit c);
    wif.wready  = 1'b1;
    wif.wr_addr = a;
    wif.wdata   = d;
    wif.commit  = c;
    @(posedge clk);
    #1;
    wif.wready = 1'b0;
    wif.commit = 1'b0;
  endtask

  // Counts edges until the chosen output changes; gives up after 40 edges.
  task automatic wait_toggle(input bit use_d, output int cnt);
    logic start;
    start = use_d ? dout : sout;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (((use_d ? dout : sout) === start) && cnt < 40);
  endtask

  initial begin
    axi_rstn = 1'b0;
    rstn = 1'b1;
    sin = 1'b0;
    din = 1'b0;
    wif.wready = 1'b0;
    wif.wr_addr = '0;
    wif.wdata = '0;
    wif.commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sout", sout, 0);
    chk("rst_dout", dout, 0);
    chk("rst_weight", weight_active, 0);
    chk("rst_cnt", dut.u_ch_s.cnt_q, 0);
    axi_rstn = 1'b1;
    @(posedge clk);
    #1;

    // w=0: both directions take the base delay
    sin = 1'b1;
    wait_toggle(1'b0, n);
    chk("w0_rise", n, 8);
    chk("w0_dout", dout, 0);
    sin = 1'b0;
    wait_toggle(1'b0, n);
    chk("w0_fall", n, 8);

    // w=3: mismatch 11, agreement 5
    wr(ADDR, 32'd3, 1'b0);
    wr(32'd0, 32'd0, 1'b1);
    chk("w3_active", weight_active, 3);
    sin = 1'b1;
    wait_toggle(1'b0, n);
    chk("w3_mis", n, 11);
    din = 1'b1;
    wait_toggle(1'b1, n);
    chk("w3_match", n, 5);

    // most-negative code saturates to -7: targets 1 and 15
    wr(ADDR, 32'h0000_0008, 1'b1);
    chk("wneg_active", weight_active, -7);
    sin = 1'b0;
    wait_toggle(1'b0, n);
    chk("wneg_mis", n, 1);
    din = 1'b0;
    wait_toggle(1'b1, n);
    chk("wneg_match", n, 15);

    // short pulse is cancelled
    wr(ADDR, 32'd0, 1'b1);
    sin = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("pulse_sout", sout, 0);
    end
    chk("pulse_cnt3", dut.u_ch_s.cnt_q, 3);
    sin = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_after", sout, 0);
    chk("pulse_cnt0", dut.u_ch_s.cnt_q, 0);

    // shadow/commit behaviour
    wr(ADDR, 32'd5, 1'b0);
    chk("nocommit", weight_active, 0);
    wr(ADDR + 32'd4, 32'd2, 1'b1);
    chk("badaddr", weight_active, 5);
    wr(ADDR, 32'd4, 1'b1);
    chk("samecycle", weight_active, 4);

    // target drops below running count mid-flight
    wr(ADDR, 32'd0, 1'b1);
    sin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    wr(ADDR, 32'h0000_0009, 1'b1);
    chk("drop_weight", weight_active, -7);
    chk("drop_pending", sout, 0);
    wait_toggle(1'b0, n);
    chk("drop_fire", n, 1);
    sin = 1'b0;
    wait_toggle(1'b0, n);
    chk("drop_fall", n, 15);

    // rstn low mid-count
    wr(ADDR, 32'd4, 1'b1);
    din = 1'b1;
    wait_toggle(1'b1, n);
    chk("w4_dout", n, 12);
    sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("en_sout", sout, 0);
    chk("en_dout", dout, 0);
    chk("en_cnt", dut.u_ch_s.cnt_q, 0);
    chk("en_weight", weight_active, 4);
    rstn = 1'b1;
    sin = 1'b0;
    wait_toggle(1'b1, n);
    chk("en_resume", n, 12);

    // asynchronous reset mid-count; pending transition is lost
    sin = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    axi_rstn = 1'b0;
    #1;
    chk("arst_sout", sout, 0);
    chk("arst_dout", dout, 0);
    chk("arst_weight", weight_active, 0);
    chk("arst_cnt", dut.u_ch_s.cnt_q, 0);
    @(posedge clk);
    #1;
    axi_rstn = 1'b1;
    wait_toggle(1'b0, n);
    chk("arst_resume", n, 8);
    chk("arst_dout1", dout, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
